// File: rtl/search_pkg.sv
// ---------------------------------------------------------------------------
// search_pkg
// Types and default sizes shared by the search scheduler and its arbiter.
//   state_t      : scheduler FSM states (IDLE -> LAUNCH -> WAIT -> RESPOND)
//   DEF_N_REQ    : default number of requesters
//   DEF_KEY_W    : default search key width
//   DEF_IDX_W    : default engine result index width
//   DEF_TIMEOUT  : default number of WAIT cycles before the search is aborted
// ---------------------------------------------------------------------------
package search_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_KEY_W   = 32;
   localparam int DEF_IDX_W   = 32;
   localparam int DEF_TIMEOUT = 100;

endpackage

// File: rtl/search_scheduler_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The winner is the first asserted
// request at or after position i_ptr+1, wrapping modulo N.
// Ports:
//   i_req       in   N       request vector
//   i_ptr       in   PW      index of the previous winner
//   o_grant     out  N       one-hot grant (all zero when nothing requests)
//   o_grantIdx  out  PW      binary index of the winner
//   o_any       out  1       at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter
   import search_pkg::*;
#(
   parameter int N  = DEF_N_REQ,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_grantIdx,
   output logic          o_any
);

   // Walk the offsets from farthest to nearest so the nearest asserted
   // request after the pointer is the last one written and therefore wins.
   always_comb begin
      o_grantIdx = '0;
      o_any      = 1'b0;
      for (int off = N; off >= 1; off--) begin
         if (i_req[(int'(i_ptr) + off) % N]) begin
            o_grantIdx = PW'((int'(i_ptr) + off) % N);
            o_any      = 1'b1;
         end
      end
   end

   // Expand the winning index to a one-hot vector.
   always_comb begin
      o_grant = '0;
      for (int r = 0; r < N; r++) begin
         o_grant[r] = o_any && (o_grantIdx == PW'(r));
      end
   end

endmodule

// File: rtl/search_scheduler.sv
// ---------------------------------------------------------------------------
// search_scheduler
// Shares one search engine between N_REQ requesters. A round-robin arbiter
// picks a requester, its key is latched and the engine is launched. The
// scheduler then waits for the engine's done strobe or a timeout and returns
// found/index/timeout to the granted requester.
// Ports:
//   clock         in   1             rising-edge clock
//   reset         in   1             synchronous, active-low
//   req_valid     in   N_REQ         per-requester request
//   req_key       in   N_REQ*KEY_W   packed keys, requester r at [r*KEY_W +: KEY_W]
//   req_ready     out  N_REQ         one-hot acceptance pulse
//   resp_valid    out  N_REQ         one-hot response pulse
//   resp_found    out  1             engine reported a match
//   resp_timeout  out  1             search was aborted
//   resp_index    out  IDX_W         engine index at completion/abort
//   eng_start     out  1             engine launch pulse
//   eng_key       out  KEY_W         key of the current/last search
//   eng_abort     out  1             engine abort pulse
//   eng_done      in   1             engine completion strobe
//   eng_found     in   1             engine match flag, valid with eng_done
//   eng_index     in   IDX_W         engine's current index
//   busy          out  1             a transaction is in flight
// ---------------------------------------------------------------------------
module search_scheduler
   import search_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int KEY_W   = DEF_KEY_W,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*KEY_W-1:0] req_key,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       resp_valid,
   output logic                   resp_found,
   output logic                   resp_timeout,
   output logic [IDX_W-1:0]       resp_index,
   output logic                   eng_start,
   output logic [KEY_W-1:0]       eng_key,
   output logic                   eng_abort,
   input  logic                   eng_done,
   input  logic                   eng_found,
   input  logic [IDX_W-1:0]       eng_index,
   output logic                   busy
);

   localparam int PW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t             r_state;
   state_t             w_nextState;
   logic [PW-1:0]      r_rrPtr;
   logic [PW-1:0]      r_grantIdx;
   logic [TW-1:0]      r_timer;
   logic [KEY_W-1:0]   r_engKey;
   logic               r_respFound;
   logic               r_respTimeout;
   logic [IDX_W-1:0]   r_respIndex;

   logic [N_REQ-1:0]   w_grant;
   logic [PW-1:0]      w_grantIdx;
   logic               w_any;
   logic [KEY_W-1:0]   w_selKey;
   logic [N_REQ-1:0]   w_grantOneHot;
   logic               w_timerExpired;

   rr_arbiter #(
      .N  (N_REQ),
      .PW (PW)
   ) u_arbiter (
      .i_req      (req_valid),
      .i_ptr      (r_rrPtr),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx),
      .o_any      (w_any)
   );

   // Key of the requester the arbiter is currently choosing.
   always_comb begin
      w_selKey = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (w_grantIdx == PW'(r)) begin
            w_selKey = req_key[r*KEY_W +: KEY_W];
         end
      end
   end

   // One-hot form of the latched grant, used to steer the response pulse.
   always_comb begin
      w_grantOneHot = '0;
      for (int r = 0; r < N_REQ; r++) begin
         w_grantOneHot[r] = (r_grantIdx == PW'(r));
      end
   end

   // The timer is zero in the first WAIT cycle, so this fires in WAIT
   // cycle number TIMEOUT.
   assign w_timerExpired = (r_timer == TW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and pulse outputs. Everything is forced low while reset is
   // asserted so a transaction cut off by reset never shows a response,
   // abort or acceptance to the outside world.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      resp_valid  = '0;
      eng_start   = 1'b0;
      eng_abort   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               req_ready   = w_grant;
               w_nextState = LAUNCH;
            end
         end
         LAUNCH: begin
            busy        = 1'b1;
            eng_start   = 1'b1;
            w_nextState = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (eng_done) begin
               w_nextState = RESPOND;
            end else if (w_timerExpired) begin
               eng_abort   = 1'b1;
               w_nextState = RESPOND;
            end
         end
         RESPOND: begin
            busy        = 1'b1;
            resp_valid  = w_grantOneHot;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (!reset) begin
         w_nextState = IDLE;
         req_ready   = '0;
         resp_valid  = '0;
         eng_start   = 1'b0;
         eng_abort   = 1'b0;
         busy        = 1'b0;
      end
   end

   // Datapath registers: grant and key capture at acceptance, timeout
   // counter, result capture on done/abort, and the round-robin pointer
   // which only advances once the response has been delivered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rrPtr       <= PW'(N_REQ - 1);
         r_grantIdx    <= '0;
         r_timer       <= '0;
         r_engKey      <= '0;
         r_respFound   <= 1'b0;
         r_respTimeout <= 1'b0;
         r_respIndex   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grantIdx <= w_grantIdx;
                  r_engKey   <= w_selKey;
               end
            end
            LAUNCH: begin
               r_timer <= '0;
            end
            WAIT: begin
               r_timer <= r_timer + TW'(1);
               if (eng_done) begin
                  r_respFound   <= eng_found;
                  r_respIndex   <= eng_index;
                  r_respTimeout <= 1'b0;
               end else if (w_timerExpired) begin
                  r_respFound   <= 1'b0;
                  r_respIndex   <= eng_index;
                  r_respTimeout <= 1'b1;
               end
            end
            RESPOND: begin
               r_rrPtr <= r_grantIdx;
            end
            default: begin
               r_timer <= '0;
            end
         endcase
      end
   end

   assign eng_key      = r_engKey;
   assign resp_found   = r_respFound;
   assign resp_timeout = r_respTimeout;
   assign resp_index   = r_respIndex;

endmodule
